// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
// Module      : mdio_master
// Description : IEEE 802.3 MDIO management master. Executes one host command
//               per frame, either Clause 22 or Clause 45. The MDC divider and
//               the preamble length are configurable, the preamble can be
//               suppressed per command, and a missing PHY is detected on the
//               second turnaround bit of read frames.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_DIV      CLK cycles per MDC half-period (2..65535)
//   PREAMBLE_LEN number of preamble '1' bits (1..32)
//   SUPPORT_C45  1 accepts Clause 45 commands, 0 treats CMD_C45 as 0
// Ports
//   CLK, RST      system clock, synchronous active-high reset
//   CMD_VALID     command request (hold until accepted)
//   CMD_READY     engine idle; accept on CMD_VALID && CMD_READY
//   CMD_C45       0 = Clause 22 (ST=01), 1 = Clause 45 (ST=00)
//   CMD_OP        opcode field
//   CMD_PHY       PHYAD / PRTAD
//   CMD_REG       REGAD / DEVAD
//   CMD_DATA      write data or C45 address
//   PRE_SUPPRESS  1 omits the preamble for this command
//   RSP_VALID     one-cycle completion strobe
//   RSP_DATA      read data, held until the next RSP_VALID
//   RSP_ERR       read turnaround error (no PHY response)
//   BUSY          command in flight
//   MDC           management clock
//   MDIO          management data, tri-stated when not driven by the master
// ============================================================================
module mdio_master #(
  parameter int CLK_DIV      = 30,
  parameter int PREAMBLE_LEN = 32,
  parameter int SUPPORT_C45  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_C45,
  input  logic [1:0]  CMD_OP,
  input  logic [4:0]  CMD_PHY,
  input  logic [4:0]  CMD_REG,
  input  logic [15:0] CMD_DATA,
  input  logic        PRE_SUPPRESS,
  output logic        RSP_VALID,
  output logic [15:0] RSP_DATA,
  output logic        RSP_ERR,
  output logic        BUSY,
  output logic        MDC,
  inout  wire         MDIO
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_HDR  = 3'd2;
  localparam logic [2:0] ST_TA   = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // Phase counter needs 17 bits to reach 2*65535-1.
  localparam logic [16:0] PH_RISE_M1 = 17'(CLK_DIV - 1);
  localparam logic [16:0] PH_RISE    = 17'(CLK_DIV);
  localparam logic [16:0] PH_LAST    = 17'(2 * CLK_DIV - 1);

  // Bit counters count down to zero; each value is "bits in state minus one".
  localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_LEN - 1);
  localparam logic [5:0] HDR_LAST  = 6'd13;  // ST(2) OP(2) PHY(5) REG(5)
  localparam logic [5:0] TA_LAST   = 6'd1;
  localparam logic [5:0] DATA_LAST = 6'd15;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]  state;
  logic [16:0] ph;
  logic [5:0]  bit_cnt;
  logic [31:0] frame_sr;    // ST OP PHY REG TA DATA, shifted out MSB first
  logic [15:0] rx_sr;
  logic        is_read;
  logic        ta_err;
  logic        mdc_q;
  logic [15:0] rsp_data_q;
  logic        rsp_err_q;

  logic        c45_eff;
  logic        cmd_read;
  logic        cmd_legal;
  logic [1:0]  cmd_st;
  logic        bit_end;
  logic        mdio_in;
  logic        mdio_oe;
  logic        mdio_do;

  // --------------------------------------------------------------------------
  // Clause 45 support is removed at elaboration when not wanted
  // --------------------------------------------------------------------------
  generate
    if (SUPPORT_C45 != 0) begin : g_c45
      assign c45_eff = CMD_C45;
    end else begin : g_c22_only
      assign c45_eff = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Command decode
  // --------------------------------------------------------------------------
  // C45 read (11) and read-increment (10) both have OP[1] set.
  assign cmd_read  = c45_eff ? CMD_OP[1] : (CMD_OP == 2'b10);
  // Every C45 opcode is legal; C22 only defines write (01) and read (10).
  assign cmd_legal = c45_eff | (CMD_OP == 2'b01) | (CMD_OP == 2'b10);
  assign cmd_st    = c45_eff ? 2'b00 : 2'b01;

  assign bit_end   = (ph == PH_LAST);
  assign mdio_in   = MDIO;

  // --------------------------------------------------------------------------
  // Frame engine
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      ph         <= '0;
      bit_cnt    <= '0;
      frame_sr   <= '0;
      rx_sr      <= '0;
      is_read    <= 1'b0;
      ta_err     <= 1'b0;
      mdc_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ph    <= '0;
          mdc_q <= 1'b0;
          if (CMD_VALID) begin
            // All command fields are captured here; the host may change
            // them freely once the command has been accepted.
            frame_sr <= {cmd_st, CMD_OP, CMD_PHY, CMD_REG, 2'b10, CMD_DATA};
            is_read  <= cmd_read;
            rx_sr    <= '0;
            ta_err   <= 1'b0;
            if (!cmd_legal) begin
              // Nothing goes on the wire; report the error straight away.
              state      <= ST_DONE;
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
            end else if (PRE_SUPPRESS) begin
              state   <= ST_HDR;
              bit_cnt <= HDR_LAST;
            end else begin
              state   <= ST_PRE;
              bit_cnt <= PRE_LAST;
            end
          end
        end

        ST_PRE, ST_HDR, ST_TA, ST_DATA: begin
          if (bit_end) begin
            ph <= '0;
          end else begin
            ph <= ph + 17'd1;
          end

          // MDC is registered so it is glitch-free: high for ph in
          // [CLK_DIV, 2*CLK_DIV-1], low otherwise.
          if (ph == PH_RISE_M1) begin
            mdc_q <= 1'b1;
          end else if (bit_end) begin
            mdc_q <= 1'b0;
          end

          // Sample on the cycle MDC is high for the first time, i.e. half a
          // bit period after the PHY last changed the line.
          if ((ph == PH_RISE) && is_read) begin
            if ((state == ST_TA) && (bit_cnt == 6'd0)) begin
              ta_err <= mdio_in;
            end
            if (state == ST_DATA) begin
              rx_sr <= {rx_sr[14:0], mdio_in};
            end
          end

          if (bit_end) begin
            // The preamble bits are constant ones and do not consume the
            // frame shift register.
            if (state != ST_PRE) begin
              frame_sr <= {frame_sr[30:0], 1'b0};
            end
            if (bit_cnt != 6'd0) begin
              bit_cnt <= bit_cnt - 6'd1;
            end else begin
              case (state)
                ST_PRE: begin
                  state   <= ST_HDR;
                  bit_cnt <= HDR_LAST;
                end
                ST_HDR: begin
                  state   <= ST_TA;
                  bit_cnt <= TA_LAST;
                end
                ST_TA: begin
                  state   <= ST_DATA;
                  bit_cnt <= DATA_LAST;
                end
                default: begin
                  // Last data bit: the final read sample was taken at
                  // ph == CLK_DIV, so rx_sr is already complete.
                  state      <= ST_DONE;
                  rsp_data_q <= is_read ? rx_sr : 16'h0000;
                  rsp_err_q  <= is_read & ta_err;
                end
              endcase
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          ph    <= '0;
          mdc_q <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          ph    <= '0;
          mdc_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // MDIO drive: decoded from flops that only change at bit boundaries, so the
  // line moves at ph == 0 and is released as soon as the frame leaves DATA.
  // Read frames hand the line to the PHY for turnaround and data.
  // --------------------------------------------------------------------------
  assign mdio_oe = (state == ST_PRE) || (state == ST_HDR) ||
                   (((state == ST_TA) || (state == ST_DATA)) && !is_read);
  assign mdio_do = (state == ST_PRE) ? 1'b1 : frame_sr[31];
  assign MDIO    = mdio_oe ? mdio_do : 1'bz;

  // --------------------------------------------------------------------------
  // Host-side outputs
  // --------------------------------------------------------------------------
  assign CMD_READY = (state == ST_IDLE);
  assign BUSY      = (state != ST_IDLE);
  assign RSP_VALID = (state == ST_DONE);
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;
  assign MDC       = mdc_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdio_master
// Description : Directed self-checking bench for mdio_master with a small PHY
//               model on the MDC/MDIO pins (pull-up, serial capture, optional
//               read response).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_master;

  localparam int CLK_DIV = 4;
  localparam int PRE_LEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_c45 = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_phy = 5'd0;
  logic [4:0]  cmd_reg = 5'd0;
  logic [15:0] cmd_data = 16'h0000;
  logic        pre_suppress = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        mdc;
  wire         mdio;

  // PHY model pin drive plus board pull-up.
  logic        phy_oe = 1'b0;
  logic        phy_do = 1'b0;
  assign mdio = phy_oe ? phy_do : 1'bz;
  pullup pu_mdio (mdio);

  int          errors = 0;
  int          checks = 0;

  mdio_master #(
    .CLK_DIV      (CLK_DIV),
    .PREAMBLE_LEN (PRE_LEN),
    .SUPPORT_C45  (1)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .CMD_VALID    (cmd_valid),
    .CMD_READY    (cmd_ready),
    .CMD_C45      (cmd_c45),
    .CMD_OP       (cmd_op),
    .CMD_PHY      (cmd_phy),
    .CMD_REG      (cmd_reg),
    .CMD_DATA     (cmd_data),
    .PRE_SUPPRESS (pre_suppress),
    .RSP_VALID    (rsp_valid),
    .RSP_DATA     (rsp_data),
    .RSP_ERR      (rsp_err),
    .BUSY         (busy),
    .MDC          (mdc),
    .MDIO         (mdio)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // PHY model: capture every bit at MDC rise; when enabled, answer a read by
  // driving 0 on the second TA bit and then phy_data MSB first, changing the
  // line on MDC fall.
  // --------------------------------------------------------------------------
  int          rise_cnt = 0;
  logic [63:0] cap = '0;
  int          base = 0;
  logic        phy_en = 1'b0;
  int          phy_ta2 = 47;
  logic [15:0] phy_data = 16'h0000;

  always @(posedge mdc) begin
    rise_cnt <= rise_cnt + 1;
    cap      <= {cap[62:0], mdio};
  end

  always @(negedge mdc) begin : phy_drive
    int k;
    k = rise_cnt - base;
    if (phy_en && (k == phy_ta2)) begin
      phy_oe <= 1'b1;
      phy_do <= 1'b0;
    end else if (phy_en && (k > phy_ta2) && (k <= phy_ta2 + 16)) begin
      phy_oe <= 1'b1;
      phy_do <= phy_data[4'(15 - (k - phy_ta2 - 1))];
    end else begin
      phy_oe <= 1'b0;
      phy_do <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  logic [15:0] mdc_hist = '0;
  logic        busy_at1 = 1'b0;
  logic        ready_at1 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic c45, input logic [1:0] op, input logic [4:0] phy,
                      input logic [4:0] rg, input logic [15:0] data, input logic sup);
    cmd_c45      = c45;
    cmd_op       = op;
    cmd_phy      = phy;
    cmd_reg      = rg;
    cmd_data     = data;
    pre_suppress = sup;
    cmd_valid    = 1'b1;
  endtask

  // Called in the cycle the command is accepted; lat counts edges until
  // RSP_VALID is seen. Fields are scrambled after accept to prove capture.
  task automatic wait_rsp(input int limit, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        cmd_valid    = 1'b0;
        cmd_op       = ~cmd_op;
        cmd_phy      = ~cmd_phy;
        cmd_reg      = ~cmd_reg;
        cmd_data     = ~cmd_data;
        cmd_c45      = ~cmd_c45;
        pre_suppress = ~pre_suppress;
        busy_at1     = busy;
        ready_at1    = cmd_ready;
      end
      if (lat <= 16) mdc_hist[lat-1] = mdc;
    end while (!rsp_valid && (lat < limit));
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin : main
    int lat;
    int rc;
    int pulses;
    int guard;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mdc", mdc, 0);
    chk("rst_mdio_oe", dut.mdio_oe, 0);
    rst = 1'b0;

    // C22 read, PHY answers 0x0FFA
    phy_en = 1'b1; phy_ta2 = 47; phy_data = 16'h0FFA; base = rise_cnt;
    send(1'b0, 2'b10, 5'd1, 5'd0, 16'h0000, 1'b0);
    wait_rsp(600, lat);
    chk("rd_latency", lat, 513);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_data", rsp_data, 16'h0FFA);
    chk("rd_err", rsp_err, 0);
    chk("rd_mdc_wave", mdc_hist, 16'hF0F0);
    chk("rd_busy_early", busy_at1, 1);
    chk("rd_ready_early", ready_at1, 0);
    chk("rd_bits", rise_cnt - base, 64);
    chk("rd_stream", cap, 64'hFFFF_FFFF_6082_0FFA);
    @(posedge clk); #1;
    chk("rd_ready_after", cmd_ready, 1);
    chk("rd_busy_after", busy, 0);
    chk("rd_valid_pulse", rsp_valid, 0);
    chk("rd_data_hold", rsp_data, 16'h0FFA);

    // C22 write, PHY=1 REG=4 data 0x01E1
    phy_en = 1'b0; base = rise_cnt;
    send(1'b0, 2'b01, 5'd1, 5'd4, 16'h01E1, 1'b0);
    wait_rsp(600, lat);
    chk("wr_latency", lat, 513);
    chk("wr_stream", cap, 64'hFFFF_FFFF_5092_01E1);
    chk("wr_released", dut.mdio_oe, 0);
    chk("wr_err", rsp_err, 0);
    chk("wr_data", rsp_data, 0);
    @(posedge clk); #1;

    // C22 read with no PHY
    base = rise_cnt;
    send(1'b0, 2'b10, 5'd3, 5'd2, 16'h0000, 1'b0);
    wait_rsp(600, lat);
    chk("nophy_latency", lat, 513);
    chk("nophy_err", rsp_err, 1);
    chk("nophy_data", rsp_data, 16'hFFFF);
    @(posedge clk); #1;

    // C45 address frame (suppressed preamble) then back-to-back C45 read
    base = rise_cnt;
    send(1'b1, 2'b00, 5'd0, 5'd1, 16'h0007, 1'b1);
    wait_rsp(300, lat);
    chk("c45a_latency", lat, 257);
    chk("c45a_bits", rise_cnt - base, 32);
    chk("c45a_stream", cap[31:0], 32'h0006_0007);
    chk("c45a_err", rsp_err, 0);
    chk("c45a_data", rsp_data, 0);
    phy_en = 1'b1; phy_ta2 = 15; phy_data = 16'hBEEF; base = rise_cnt;
    send(1'b1, 2'b11, 5'd0, 5'd1, 16'h1234, 1'b1);
    chk("b2b_ready_low", cmd_ready, 0);
    @(posedge clk); #1;
    chk("b2b_ready_rise", cmd_ready, 1);
    wait_rsp(300, lat);
    chk("c45r_latency", lat, 257);
    chk("c45r_stream", cap[31:0], 32'h3006_BEEF);
    chk("c45r_data", rsp_data, 16'hBEEF);
    chk("c45r_err", rsp_err, 0);
    @(posedge clk); #1;

    // Reset in the middle of a read
    phy_en = 1'b0; base = rise_cnt;
    send(1'b0, 2'b10, 5'd1, 5'd0, 16'h0000, 1'b0);
    guard = 0;
    do begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      guard++;
    end while (((rise_cnt - base) < 21) && (guard < 1000));
    chk("abort_reached_bit20", rise_cnt - base, 21);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_mdc", mdc, 0);
    chk("abort_released", dut.mdio_oe, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_valid", rsp_valid, 0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
    end
    chk("abort_no_rsp", pulses, 0);
    base = rise_cnt;
    send(1'b0, 2'b01, 5'd2, 5'd9, 16'hA5A5, 1'b0);
    wait_rsp(600, lat);
    chk("post_abort_latency", lat, 513);
    chk("post_abort_stream", cap, 64'hFFFF_FFFF_5126_A5A5);
    @(posedge clk); #1;

    // Illegal C22 opcode 11
    rc = rise_cnt;
    send(1'b0, 2'b11, 5'd1, 5'd0, 16'hFFFF, 1'b0);
    wait_rsp(10, lat);
    chk("ill_latency", lat, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_data", rsp_data, 0);
    chk("ill_no_mdc", rise_cnt - rc, 0);
    @(posedge clk); #1;
    chk("ill_ready_after", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
